// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl
// Protocol sequencer between the byte-level SPI slave datapath and the
// peripheral register bus. A frame is one command byte followed by data
// bytes. Each data byte is handled at an auto-incrementing address.
//
// Command byte: bit[DATA_WIDTH-1] = R/nW (1 = read), bits[ADDR_WIDTH-1:0] = start
// address. A command of all ones clears the sticky err flag. The rest of
// that frame is then ignored.
//
// Ports
//   Clk, Rst_n        system clock, asynchronous active-low reset
//   ss_n              slave select, already synchronised to Clk (1 = deselected)
//   rx_valid/rx_data  received byte strobe and data from the datapath
//   tx_data/tx_load   next byte to shift out, and a one-cycle latch strobe
//   reg_*             register bus request/response
//   busy              state is not IDLE
//   err               sticky error flag (timeout or overrun)
//   frame_done        one-cycle pulse when a frame has fully retired
//   dbg_state         current FSM state encoding, for observation
//
// Bus handshake: reg_req rises together with a stable reg_we/reg_addr/reg_wdata.
// These signals hold until the cycle after the one-cycle reg_ack pulse, or
// until the timeout fires. The request then drops for at least one cycle
// before the next transaction.
module spi_slave_reg_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  ss_n,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack,
  output logic                  busy,
  output logic                  err,
  output logic                  frame_done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_RD_WAIT   = 3'd2,
    S_RD_STREAM = 3'd3,
    S_WR_STREAM = 3'd4,
    S_WR_WAIT   = 3'd5,
    S_DRAIN     = 3'd6
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [7:0]            TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t                state;
  logic                  ss_q;
  logic                  ignore_q;   // rest of frame discarded after a clear command
  logic [7:0]            tmo_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  tmo_hit;

  // The counter starts at 0 on the first cycle of the request. The request is
  // therefore held for exactly ACK_TIMEOUT cycles before it is abandoned.
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign reg_addr  = addr_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      ss_q       <= 1'b1;
      ignore_q   <= 1'b0;
      tmo_cnt    <= '0;
      addr_q     <= '0;
      tx_data    <= '0;
      tx_load    <= 1'b0;
      reg_req    <= 1'b0;
      reg_we     <= 1'b0;
      reg_wdata  <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ss_q       <= ss_n;
      tx_load    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ss_q && !ss_n) begin
            // Status byte shifted out while the command byte comes in.
            tx_data  <= {{(DATA_WIDTH-2){1'b0}}, err, 1'b1};
            tx_load  <= 1'b1;
            ignore_q <= 1'b0;
            state    <= S_CMD;
          end
        end
        S_CMD: begin
          // A byte that arrives together with ss_n high is still processed.
          // The following state then sees ss_n high and ends the frame.
          if (rx_valid) begin
            if (rx_data == ALL_ONES) begin
              err      <= 1'b0;
              ignore_q <= 1'b1;
              state    <= S_WR_STREAM;
            end else begin
              addr_q <= rx_data[ADDR_WIDTH-1:0];
              if (rx_data[DATA_WIDTH-1]) begin
                reg_req <= 1'b1;
                reg_we  <= 1'b0;
                tmo_cnt <= '0;
                state   <= S_RD_WAIT;
              end else begin
                state <= S_WR_STREAM;
              end
            end
          end else if (ss_n) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_RD_STREAM: begin
          // The incoming byte is a dummy. It only paces the next read.
          if (rx_valid) begin
            addr_q  <= addr_q + 1'b1;
            reg_req <= 1'b1;
            reg_we  <= 1'b0;
            tmo_cnt <= '0;
            state   <= S_RD_WAIT;
          end else if (ss_n) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_WR_STREAM: begin
          if (rx_valid && !ignore_q) begin
            reg_wdata <= rx_data;
            reg_req   <= 1'b1;
            reg_we    <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_WR_WAIT;
          end else if (ss_n) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_RD_WAIT, S_WR_WAIT, S_DRAIN: begin
          if (reg_ack || tmo_hit) begin
            reg_req <= 1'b0;
            tmo_cnt <= '0;
            if (!reg_ack) err <= 1'b1;
            if (reg_we) begin
              addr_q <= addr_q + 1'b1;
            end else begin
              // A read that timed out returns all ones to the master.
              tx_data <= reg_ack ? reg_rdata : ALL_ONES;
              tx_load <= 1'b1;
            end
            if (state == S_DRAIN || ss_n) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              state <= reg_we ? S_WR_STREAM : S_RD_STREAM;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (ss_n) state <= S_DRAIN;
          end
          // A byte that arrives while a transaction is outstanding is an
          // overrun. The byte is dropped.
          if (rx_valid && state != S_DRAIN) err <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
